// File: rtl/incarcator_program.sv
// Program loader: receives a framed byte stream (count, 2N data bytes high
// byte first, XOR checksum), writes N 16-bit words into instruction memory,
// and releases the processor from reset only after a clean load.
//
// state  | meaning
// IDLE   | no session since reset; waiting for start
// COUNT  | waiting for the word-count byte N
// HIGH   | waiting for the high byte of the next word
// LOW    | waiting for the low byte of the next word
// WRITE  | single-cycle memory write strobe
// CHECK  | waiting for the checksum byte
// DONE   | last session loaded with a good checksum; processor released
// ERROR  | last session failed (checksum or timeout)
module incarcator_program #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        mem_we,
    output logic [7:0]  mem_addr,
    output logic [15:0] mem_wdata,
    output logic        cpu_reset,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [1:0]  error_code,
    output logic [7:0]  loaded_count
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COUNT,
        ST_HIGH,
        ST_LOW,
        ST_WRITE,
        ST_CHECK,
        ST_DONE,
        ST_ERROR
    } state_t;

    state_t          state, next_state;
    logic [7:0]      n_q;
    logic [7:0]      high_q;
    logic [7:0]      xor_q;
    logic [7:0]      address_q;
    logic [7:0]      loaded_q;
    logic [TW-1:0]   tmo_q;
    logic [1:0]      error_code_q;
    logic [7:0]      mem_addr_q;
    logic [15:0]     mem_wdata_q;

    logic            in_rx;
    logic            accept;
    logic            start_sess;
    logic            timeout_hit;

    // State register; reset wins over every other input.
    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= next_state;
    end

    // Next-state decode and state-derived outputs.
    always_comb begin
        next_state  = state;
        in_rx       = 1'b0;
        accept      = 1'b0;
        start_sess  = 1'b0;
        timeout_hit = 1'b0;
        mem_we      = 1'b0;
        busy        = 1'b0;

        case (state)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) begin
                    next_state = ST_COUNT;
                    start_sess = 1'b1;
                end
            end
            ST_COUNT: begin
                in_rx  = 1'b1;
                busy   = 1'b1;
                accept = byte_valid;
                if (accept) next_state = (byte_data == 8'd0) ? ST_CHECK : ST_HIGH;
            end
            ST_HIGH: begin
                in_rx  = 1'b1;
                busy   = 1'b1;
                accept = byte_valid;
                if (accept) next_state = ST_LOW;
            end
            ST_LOW: begin
                in_rx  = 1'b1;
                busy   = 1'b1;
                accept = byte_valid;
                if (accept) next_state = ST_WRITE;
            end
            ST_WRITE: begin
                busy   = 1'b1;
                mem_we = 1'b1;
                next_state = (8'(loaded_q + 8'd1) == n_q) ? ST_CHECK : ST_HIGH;
            end
            ST_CHECK: begin
                in_rx  = 1'b1;
                busy   = 1'b1;
                accept = byte_valid;
                if (accept) next_state = (byte_data == xor_q) ? ST_DONE : ST_ERROR;
            end
            default: next_state = ST_IDLE;
        endcase

        // The idle counter only advances while a byte is awaited.
        if (in_rx && !accept && (tmo_q == TMO_LAST)) begin
            timeout_hit = 1'b1;
            next_state  = ST_ERROR;
        end
    end

    assign byte_ready   = in_rx;
    assign cpu_reset    = (state != ST_DONE);
    assign done         = (state == ST_DONE);
    assign error        = (state == ST_ERROR);
    assign error_code   = error_code_q;
    assign loaded_count = loaded_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;

    // Session datapath: byte capture, running checksum, address and timeout.
    // mem_addr/mem_wdata are loaded on the low-byte accept so they are valid
    // during WRITE and then hold while the internal address moves on.
    always_ff @(posedge clk) begin
        if (reset) begin
            n_q          <= '0;
            high_q       <= '0;
            xor_q        <= '0;
            address_q    <= '0;
            loaded_q     <= '0;
            tmo_q        <= '0;
            error_code_q <= 2'b00;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else if (start_sess) begin
            xor_q        <= '0;
            address_q    <= '0;
            loaded_q     <= '0;
            tmo_q        <= '0;
            error_code_q <= 2'b00;
        end else begin
            if (in_rx) begin
                if (accept) tmo_q <= '0;
                else        tmo_q <= tmo_q + 1'b1;
            end

            if (accept) begin
                case (state)
                    ST_COUNT: begin
                        n_q   <= byte_data;
                        xor_q <= xor_q ^ byte_data;
                    end
                    ST_HIGH: begin
                        high_q <= byte_data;
                        xor_q  <= xor_q ^ byte_data;
                    end
                    ST_LOW: begin
                        xor_q       <= xor_q ^ byte_data;
                        mem_addr_q  <= address_q;
                        mem_wdata_q <= {high_q, byte_data};
                    end
                    ST_CHECK: begin
                        if (byte_data != xor_q) error_code_q <= 2'b01;
                    end
                    default: ;
                endcase
            end

            if (timeout_hit) error_code_q <= 2'b10;

            if (state == ST_WRITE) begin
                address_q <= address_q + 8'd1;
                loaded_q  <= loaded_q + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_incarcator_program.sv
// Directed bench for the program loader: reset, good/bad/empty loads,
// timeout latency and a reset in the middle of a session.
module tb_incarcator_program;

    localparam int TMO = 32;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic        cpu_reset;
    logic        busy;
    logic        done;
    logic        error;
    logic [1:0]  error_code;
    logic [7:0]  loaded_count;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0]  wr_addr [0:63];
    logic [15:0] wr_data [0:63];
    int          wr_n    = 0;
    int          run     = 0;
    int          max_run = 0;
    int          base;
    int          k;

    incarcator_program #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .byte_valid   (byte_valid),
        .byte_data    (byte_data),
        .byte_ready   (byte_ready),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .cpu_reset    (cpu_reset),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .error_code   (error_code),
        .loaded_count (loaded_count)
    );

    always #5 clk = ~clk;

    // Capture every memory write and the longest run of consecutive strobes.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            if (wr_n < 64) begin
                wr_addr[wr_n] = mem_addr;
                wr_data[wr_n] = mem_wdata;
            end
            wr_n = wr_n + 1;
            run  = run + 1;
            if (run > max_run) max_run = run;
        end else begin
            run = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        byte_valid = 1'b1;
        byte_data  = b;
        n = 0;
        while (byte_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("byte_ready_wait", {31'd0, byte_ready}, 32'd1);
        tick();
        byte_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b1; byte_valid = 1'b1; byte_data = 8'hFF;
        tick();
        tick();
        chk("rst_byte_ready", {31'd0, byte_ready}, 32'd0);
        chk("rst_mem_we",     {31'd0, mem_we},     32'd0);
        chk("rst_mem_addr",   {24'd0, mem_addr},   32'd0);
        chk("rst_mem_wdata",  {16'd0, mem_wdata},  32'd0);
        chk("rst_cpu_reset",  {31'd0, cpu_reset},  32'd1);
        chk("rst_busy",       {31'd0, busy},       32'd0);
        chk("rst_done",       {31'd0, done},       32'd0);
        chk("rst_error",      {31'd0, error},      32'd0);
        chk("rst_error_code", {30'd0, error_code}, 32'd0);
        chk("rst_loaded",     {24'd0, loaded_count}, 32'd0);
        reset = 1'b0; start = 1'b0; byte_valid = 1'b0;
        tick();
        chk("idle_ready", {31'd0, byte_ready}, 32'd0);

        // Good load: 02 12 34 AB CD, checksum 42.
        base = wr_n;
        pulse_start();
        chk("good_busy",  {31'd0, busy},       32'd1);
        chk("good_ready", {31'd0, byte_ready}, 32'd1);
        send_byte(8'h02);
        send_byte(8'h12);
        send_byte(8'h34);
        chk("good_we0",    {31'd0, mem_we},     32'd1);
        chk("good_addr0",  {24'd0, mem_addr},   32'h00);
        chk("good_data0",  {16'd0, mem_wdata},  32'h1234);
        chk("good_wr_rdy", {31'd0, byte_ready}, 32'd0);
        send_byte(8'hAB);
        send_byte(8'hCD);
        send_byte(8'h42);
        chk("good_done",   {31'd0, done},         32'd1);
        chk("good_error",  {31'd0, error},        32'd0);
        chk("good_loaded", {24'd0, loaded_count}, 32'd2);
        chk("good_cpurst", {31'd0, cpu_reset},    32'd0);
        chk("good_busy_e", {31'd0, busy},         32'd0);
        chk("good_nwr",    wr_n - base,           32'd2);
        chk("good_wa0",    {24'd0, wr_addr[base]},    32'h00);
        chk("good_wd0",    {16'd0, wr_data[base]},    32'h1234);
        chk("good_wa1",    {24'd0, wr_addr[base+1]},  32'h01);
        chk("good_wd1",    {16'd0, wr_data[base+1]},  32'hABCD);
        chk("good_hold_a", {24'd0, mem_addr},     32'h01);
        chk("good_hold_d", {16'd0, mem_wdata},    32'hABCD);
        // Bytes offered in DONE must be ignored.
        byte_valid = 1'b1; byte_data = 8'h77;
        tick(); tick(); tick();
        byte_valid = 1'b0;
        chk("done_ign_done", {31'd0, done},         32'd1);
        chk("done_ign_nwr",  wr_n - base,           32'd2);
        chk("done_ign_cnt",  {24'd0, loaded_count}, 32'd2);

        // Bad checksum: same stream ending in 43.
        base = wr_n;
        pulse_start();
        chk("bad_clr_done", {31'd0, done},         32'd0);
        chk("bad_clr_cnt",  {24'd0, loaded_count}, 32'd0);
        send_byte(8'h02);
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'hAB);
        send_byte(8'hCD);
        send_byte(8'h43);
        chk("bad_error",  {31'd0, error},      32'd1);
        chk("bad_code",   {30'd0, error_code}, 32'd1);
        chk("bad_cpurst", {31'd0, cpu_reset},  32'd1);
        chk("bad_done",   {31'd0, done},       32'd0);
        chk("bad_nwr",    wr_n - base,         32'd2);
        chk("bad_wd1",    {16'd0, wr_data[base+1]}, 32'hABCD);

        // Empty program.
        base = wr_n;
        pulse_start();
        chk("empty_clr_err",  {31'd0, error},      32'd0);
        chk("empty_clr_code", {30'd0, error_code}, 32'd0);
        send_byte(8'h00);
        send_byte(8'h00);
        chk("empty_done",   {31'd0, done},         32'd1);
        chk("empty_loaded", {24'd0, loaded_count}, 32'd0);
        chk("empty_cpurst", {31'd0, cpu_reset},    32'd0);
        chk("empty_nwr",    wr_n - base,           32'd0);

        // Timeout: 01 12 then silence; error exactly TMO cycles after the 12.
        base = wr_n;
        pulse_start();
        send_byte(8'h01);
        send_byte(8'h12);
        k = 0;
        while (error !== 1'b1 && k < TMO + 10) begin
            tick();
            k++;
        end
        chk("tmo_latency", k,                  TMO);
        chk("tmo_error",   {31'd0, error},      32'd1);
        chk("tmo_code",    {30'd0, error_code}, 32'd2);
        chk("tmo_nwr",     wr_n - base,         32'd0);
        chk("tmo_cpurst",  {31'd0, cpu_reset},  32'd1);

        // Reset mid-load, then restart with 01 55 66 32.
        base = wr_n;
        pulse_start();
        send_byte(8'h02);
        send_byte(8'h12);
        send_byte(8'h34);
        tick();
        chk("mid_nwr1", wr_n - base, 32'd1);
        reset = 1'b1; start = 1'b1; byte_valid = 1'b1; byte_data = 8'h99;
        tick();
        reset = 1'b0; start = 1'b0; byte_valid = 1'b0;
        chk("mid_busy",   {31'd0, busy},         32'd0);
        chk("mid_ready",  {31'd0, byte_ready},   32'd0);
        chk("mid_cpurst", {31'd0, cpu_reset},    32'd1);
        chk("mid_loaded", {24'd0, loaded_count}, 32'd0);
        chk("mid_addr",   {24'd0, mem_addr},     32'd0);
        chk("mid_nwr2",   wr_n - base,           32'd1);
        tick();
        chk("mid_idle", {31'd0, busy}, 32'd0);
        base = wr_n;
        pulse_start();
        send_byte(8'h01);
        send_byte(8'h55);
        pulse_start();
        chk("mid_start_ign_busy", {31'd0, busy},         32'd1);
        chk("mid_start_ign_cnt",  {24'd0, loaded_count}, 32'd0);
        send_byte(8'h66);
        chk("mid_we",   {31'd0, mem_we},    32'd1);
        chk("mid_wa",   {24'd0, mem_addr},  32'h00);
        chk("mid_wd",   {16'd0, mem_wdata}, 32'h5566);
        send_byte(8'h32);
        chk("mid_done",   {31'd0, done},         32'd1);
        chk("mid_loaded2", {24'd0, loaded_count}, 32'd1);
        chk("mid_nwr3",   wr_n - base,           32'd1);
        chk("we_one_cycle", max_run,             32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
